neander_prog_loader: RTL and testbench

NEANDER_PROG_LOADER -- requirements
Module: neander_prog_loader

---
 rtl/neander_prog_loader_if.sv | 24 ++
 rtl/neander_prog_loader.sv | 116 +++++++++++
 tb/tb_neander_prog_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neander_prog_loader_if.sv
// neander_prog_loader_if: host byte streams plus RAM load/readback bus of the program loader
// slave  = loader side: consumes rx, produces tx, drives RAM load and read address
// master = host/RAM side: the opposite directions
interface neander_prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       mem_load_en;
  logic [7:0] mem_load_addr;
  logic [7:0] mem_load_data;
  logic [7:0] mem_read_addr;
  logic [7:0] mem_read_data;
  modport slave (
    input  rx_data, rx_valid, tx_ready, mem_read_data,
    output rx_ready, tx_data, tx_valid, mem_load_en, mem_load_addr, mem_load_data, mem_read_addr
  );
  modport master (
    output rx_data, rx_valid, tx_ready, mem_read_data,
    input  rx_ready, tx_data, tx_valid, mem_load_en, mem_load_addr, mem_load_data, mem_read_addr
  );
endinterface

// File: rtl/neander_prog_loader.sv
// neander_prog_loader: byte-command loader that writes/reads Neander RAM and controls CPU reset
// Ports: clk, rst_n (async active-low); bus (slave modport: rx stream in, tx stream out,
// RAM load port, combinational RAM readback); cpu_reset, busy, err (sticky).
// Commands: 'W' addr len data.. -> 0xAA; 'R' addr len -> data bytes; 'G'/'H' run/halt -> 0xAA.
// Optional macro LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte to 'W' frames
// (mismatch answers 0xEE and sets err).
module neander_prog_loader (
  input  logic                        clk,
  input  logic                        rst_n,
  neander_prog_loader_if.slave        bus,
  output logic                        cpu_reset,
  output logic                        busy,
  output logic                        err
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] LEN    = 3'd2;
  localparam logic [2:0] WDATA  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM   = 3'd4;
`endif
  localparam logic [2:0] RFETCH = 3'd5;
  localparam logic [2:0] RSEND  = 3'd6;
  localparam logic [2:0] ACK    = 3'd7;
  logic [2:0] state;
  logic       rd_cmd;
  logic [7:0] addr;
  logic [8:0] cnt;
  logic [7:0] tx_q;
  logic       rx_acc;
  logic       tx_acc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif
  assign bus.rx_ready      = !(state inside {RFETCH, RSEND, ACK});
  assign bus.tx_valid      = state == RSEND || state == ACK;
  assign bus.tx_data       = tx_q;
  assign bus.mem_read_addr = addr;
  assign busy              = state != IDLE;
  assign rx_acc            = bus.rx_valid && bus.rx_ready;
  assign tx_acc            = bus.tx_valid && bus.tx_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rd_cmd            <= 1'b0;
      addr              <= 8'h00;
      cnt               <= 9'd0;
      tx_q              <= 8'h00;
      cpu_reset         <= 1'b1;
      err               <= 1'b0;
      bus.mem_load_en   <= 1'b0;
      bus.mem_load_addr <= 8'h00;
      bus.mem_load_data <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
      sum               <= 8'h00;
`endif
    end else begin
      bus.mem_load_en <= 1'b0;
      case (state)
        IDLE: if (rx_acc) begin
          rd_cmd <= bus.rx_data == 8'h52;
          if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) state <= ADDR;
          else if (bus.rx_data == 8'h47 || bus.rx_data == 8'h48) begin
            cpu_reset <= bus.rx_data == 8'h48;
            tx_q      <= 8'hAA;
            state     <= ACK;
          end else err <= 1'b1;
        end
        ADDR: if (rx_acc) begin
          addr  <= bus.rx_data;
          state <= LEN;
        end
        LEN: if (rx_acc) begin
          // a zero length byte encodes a full 256-byte transfer
          cnt   <= {bus.rx_data == 8'h00, bus.rx_data};
          state <= rd_cmd ? RFETCH : WDATA;
`ifdef LOADER_CHECKSUM_EN
          sum   <= 8'h00;
`endif
        end
        WDATA: if (rx_acc) begin
          bus.mem_load_en   <= 1'b1;
          bus.mem_load_addr <= addr;
          bus.mem_load_data <= bus.rx_data;
          addr              <= addr + 8'd1;
          cnt               <= cnt - 9'd1;
          tx_q              <= 8'hAA;
`ifdef LOADER_CHECKSUM_EN
          sum               <= sum + bus.rx_data;
          if (cnt == 9'd1) state <= CSUM;
`else
          if (cnt == 9'd1) state <= ACK;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (rx_acc) begin
          tx_q  <= bus.rx_data == sum ? 8'hAA : 8'hEE;
          err   <= err || bus.rx_data != sum;
          state <= ACK;
        end
`endif
        RFETCH: begin
          tx_q  <= bus.mem_read_data;
          state <= RSEND;
        end
        RSEND: if (tx_acc) begin
          addr  <= addr + 8'd1;
          cnt   <= cnt - 9'd1;
          state <= cnt == 9'd1 ? IDLE : RFETCH;
        end
        ACK: if (tx_acc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neander_prog_loader.sv
// tb_neander_prog_loader: randomized scenario bench for neander_prog_loader against a RAM/command model
module tb_neander_prog_loader;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [37:0] RST_OUT = {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_reset, busy, err;
  neander_prog_loader_if ifc();
  neander_prog_loader dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave), .cpu_reset(cpu_reset), .busy(busy), .err(err));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] a; logic [7:0] d; int c;} wr_t;
  logic [7:0] ram [256];
  logic [7:0] exp_ram [256];
  logic [7:0] dq [$];
  wr_t wq [$];
  int cyc = 0;
  int vec = 0;
  int miss = 0;
  logic exp_cpu = 1'b1;
  logic exp_err = 1'b0;
  assign ifc.mem_read_data = ram[ifc.mem_read_addr];
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (ifc.mem_load_en === 1'b1) begin
      ram[ifc.mem_load_addr] = ifc.mem_load_data;
      wq.push_back('{ifc.mem_load_addr, ifc.mem_load_data, cyc});
    end
  function automatic logic [37:0] outs();
    return {ifc.rx_ready, ifc.tx_valid, ifc.tx_data, ifc.mem_load_en, ifc.mem_load_addr,
            ifc.mem_load_data, ifc.mem_read_addr, cpu_reset, busy, err};
  endfunction
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    ifc.rx_data = b;
    ifc.rx_valid = 1'b1;
    while (ifc.rx_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    vec++;
    if (ifc.rx_ready !== 1'b1) begin
      miss++;
      $display("FAIL send_timeout: rx_ready=%b want 1 (byte %h)", ifc.rx_ready, b);
      ifc.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ifc.rx_valid = 1'b0;
  endtask
  task automatic recv_byte(input int stall, output logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (ifc.tx_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    vec++;
    if (ifc.tx_valid !== 1'b1) begin
      miss++;
      $display("FAIL recv_timeout: tx_valid=%b want 1", ifc.tx_valid);
      b = 8'hxx;
      return;
    end
    b = ifc.tx_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      vec++;
      if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== b) begin
        miss++;
        $display("FAIL tx_hold: valid=%b data=%h want valid=1 data=%h", ifc.tx_valid, ifc.tx_data, b);
      end
    end
    ifc.tx_ready = 1'b1;
    @(posedge clk);
    #1 ifc.tx_ready = 1'b0;
  endtask
  task automatic do_write(input logic [7:0] a, input logic bad);
    logic [7:0] s = 8'h00;
    logic [7:0] r;
    logic [7:0] want;
    int n = dq.size();
    wq.delete();
    send_byte(8'h57);
    send_byte(a);
    send_byte(8'(n));
    foreach (dq[i]) begin
      send_byte(dq[i]);
      s += dq[i];
    end
    if (CSUM_EN) send_byte(bad ? s + 8'd1 : s);
    want = (CSUM_EN && bad) ? 8'hEE : 8'hAA;
    if (want == 8'hEE) exp_err = 1'b1;
    recv_byte(0, r);
    vec++;
    if (r !== want) begin miss++; $display("FAIL write_resp: got %h want %h", r, want); end
    vec++;
    if (wq.size() != n) begin miss++; $display("FAIL write_count: got %0d want %0d", wq.size(), n); end
    for (int i = 0; i < n && i < wq.size(); i++) begin
      vec++;
      if (wq[i].a !== 8'(a + i) || wq[i].d !== dq[i] || (i > 0 && wq[i].c != wq[i-1].c + 1)) begin
        miss++;
        $display("FAIL write_pulse[%0d]: got %h<=%h cyc %0d want %h<=%h back-to-back", i, wq[i].a, wq[i].d, wq[i].c, 8'(a + i), dq[i]);
      end
    end
    foreach (dq[i]) exp_ram[8'(a + i)] = dq[i];
  endtask
  task automatic do_read(input logic [7:0] a, input int n, input int stall);
    logic [7:0] r;
    wq.delete();
    send_byte(8'h52);
    send_byte(a);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      recv_byte(stall, r);
      vec++;
      if (r !== exp_ram[8'(a + i)]) begin
        miss++;
        $display("FAIL read_data[%h]: got %h want %h", 8'(a + i), r, exp_ram[8'(a + i)]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if (ifc.tx_valid !== 1'b0) begin miss++; $display("FAIL read_no_ack: tx_valid=%b tx_data=%h want 0", ifc.tx_valid, ifc.tx_data); end
    end
    vec++;
    if (busy !== 1'b0 || wq.size() != 0) begin miss++; $display("FAIL read_idle: busy=%b writes=%0d want 0/0", busy, wq.size()); end
  endtask
  task automatic do_ctl(input logic [7:0] b);
    logic [7:0] r;
    send_byte(b);
    recv_byte($urandom_range(0, 2), r);
    exp_cpu = b == 8'h48;
    vec++;
    if (r !== 8'hAA) begin miss++; $display("FAIL ctl_resp %h: got %h want aa", b, r); end
    vec++;
    if (cpu_reset !== exp_cpu) begin miss++; $display("FAIL ctl_cpu_reset %h: got %b want %b", b, cpu_reset, exp_cpu); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (outs() !== RST_OUT) begin miss++; $display("FAIL reset_hold: got %h want %h", outs(), RST_OUT); end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (outs() !== RST_OUT) begin miss++; $display("FAIL reset_release: got %h want %h", outs(), RST_OUT); end
  endtask
  task automatic test_full_load();
    dq.delete();
    for (int i = 0; i < 256; i++) dq.push_back(8'($urandom));
    do_write(8'h00, 1'b0);
  endtask
  task automatic test_write_basic();
    dq = '{8'h11, 8'h22, 8'h33};
    do_write(8'h10, 1'b0);
  endtask
  task automatic test_write_wrap();
    dq = '{8'hA0, 8'hA1, 8'hA2};
    do_write(8'hFE, 1'b0);
  endtask
  task automatic test_read_stall();
    dq = '{8'h5A, 8'hC3};
    do_write(8'h20, 1'b0);
    do_read(8'h20, 2, 5);
  endtask
  task automatic test_cpu_ctrl();
    do_ctl(8'h47);
    do_ctl(8'h48);
    do_ctl(8'h47);
  endtask
  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          dq.delete();
          repeat ($urandom_range(1, 8)) dq.push_back(8'($urandom));
          do_write(8'($urandom), 1'b0);
        end
        1: do_read(8'($urandom), $urandom_range(1, 5), $urandom_range(0, 3));
        default: do_ctl($urandom_range(0, 1) ? 8'h47 : 8'h48);
      endcase
      vec++;
      if (err !== exp_err || cpu_reset !== exp_cpu || busy !== 1'b0) begin
        miss++;
        $display("FAIL random_status[%0d]: err=%b cpu=%b busy=%b want %b %b 0", k, err, cpu_reset, busy, exp_err, exp_cpu);
      end
    end
  endtask
  task automatic test_checksum_bad();
`ifdef LOADER_CHECKSUM_EN
    dq = '{8'h05};
    do_write(8'h00, 1'b1);
    vec++;
    if (err !== 1'b1) begin miss++; $display("FAIL csum_err: got %b want 1", err); end
    do_read(8'h00, 1, 0);
`endif
  endtask
  task automatic test_invalid_byte();
    send_byte(8'h99);
    exp_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++;
      if (ifc.tx_valid !== 1'b0 || busy !== 1'b0) begin miss++; $display("FAIL invalid_quiet: tx_valid=%b busy=%b want 0/0", ifc.tx_valid, busy); end
    end
    vec++;
    if (err !== 1'b1) begin miss++; $display("FAIL invalid_err: got %b want 1", err); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] b1 = 8'($urandom);
    wq.delete();
    send_byte(8'h57);
    send_byte(8'h40);
    send_byte(8'h04);
    send_byte(b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (outs() !== RST_OUT) begin miss++; $display("FAIL midreset_outs: got %h want %h", outs(), RST_OUT); end
    exp_cpu = 1'b1;
    exp_err = 1'b0;
    exp_ram[8'h40] = b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (ifc.mem_load_en !== 1'b0) begin miss++; $display("FAIL midreset_pulse: mem_load_en=%b want 0", ifc.mem_load_en); end
    end
    rst_n = 1'b1;
    vec++;
    if (wq.size() != 1 || wq[0].a !== 8'h40 || wq[0].d !== b1) begin
      miss++;
      $display("FAIL midreset_writes: count=%0d first=%h<=%h want 1 40<=%h", wq.size(), wq[0].a, wq[0].d, b1);
    end
    do_ctl(8'h47);
    do_read(8'h40, 2, 0);
  endtask
  initial begin
    ifc.rx_valid = 1'b0;
    ifc.rx_data = 8'h00;
    ifc.tx_ready = 1'b0;
    test_reset();
    test_full_load();
    test_write_basic();
    test_write_wrap();
    test_read_stall();
    test_cpu_ctrl();
    test_random();
    test_checksum_bad();
    test_invalid_byte();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
